// File: rtl/mic_capture_ctrl.sv
// PDM microphone capture sequencer: warms up the decimator, then scales, saturates and
// stores a programmed number of samples into a buffer through a single-beat write port.
module mic_capture_ctrl #(
  parameter int DATA_W         = 16,
  parameter int SHIFT          = 8,
  parameter int ADDR_W         = 14,
  parameter int WARMUP_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_samples,
  input  logic [31:0]       mic_data,
  input  logic              mic_data_valid,
  output logic              mic_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   captured_count,
  output logic [15:0]       drop_count
);

  localparam int WCW = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;
  localparam int SAT_MAX = (1 << (DATA_W-1)) - 1;
  localparam int SAT_MIN = -(1 << (DATA_W-1));
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, DONE} state_t;

  state_t state, next_state;

  logic [ADDR_W:0]    target;
  logic [ADDR_W:0]    clamped_len;
  logic [WCW-1:0]     warm_cnt;
  logic               start_ok;
  logic               accept;
  logic               drop;
  logic signed [31:0] shifted;
  logic [DATA_W-1:0]  sat_data;

  always_comb begin
    clamped_len = (num_samples > MAX_LEN) ? MAX_LEN : num_samples;
    shifted     = $signed(mic_data) >>> SHIFT;
    if (shifted > SAT_MAX)
      sat_data = DATA_W'(SAT_MAX);
    else if (shifted < SAT_MIN)
      sat_data = DATA_W'(SAT_MIN);
    else
      sat_data = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          if (clamped_len == '0)
            next_state = DONE;
          else if (WARMUP_SAMPLES == 0)
            next_state = CAPTURE;
          else
            next_state = WARMUP;
        end
      end
      WARMUP: begin
        if (abort)
          next_state = IDLE;
        else if (mic_data_valid && warm_cnt == WARM_LAST)
          next_state = CAPTURE;
      end
      CAPTURE: begin
        // Completion is judged on the registered count, so a beat arriving
        // alongside the final write strobe is ignored.
        if (abort)
          next_state = IDLE;
        else if (captured_count == target)
          next_state = DONE;
        else if (mic_data_valid) begin
          accept = wr_ready;
          drop   = !wr_ready;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mic_en         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      captured_count <= '0;
      drop_count     <= '0;
      target         <= '0;
      warm_cnt       <= '0;
    end else begin
      mic_en <= (next_state == WARMUP) || (next_state == CAPTURE);
      busy   <= (next_state == WARMUP) || (next_state == CAPTURE);
      done   <= (next_state == DONE);
      wr_en  <= accept;
      if (start_ok) begin
        target         <= clamped_len;
        captured_count <= '0;
        drop_count     <= '0;
        warm_cnt       <= '0;
        wr_addr        <= '0;
        wr_data        <= '0;
      end
      if (state == WARMUP && mic_data_valid && !abort)
        warm_cnt <= warm_cnt + 1'b1;
      if (accept) begin
        wr_addr        <= captured_count[ADDR_W-1:0];
        wr_data        <= sat_data;
        captured_count <= captured_count + 1'b1;
      end
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl (ADDR_W=4, SHIFT=8, WARMUP_SAMPLES=8).
module tb_mic_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  num_samples;
  logic [31:0] mic_data;
  logic        mic_data_valid;
  logic        mic_en;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic [4:0]  captured_count;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  mic_capture_ctrl #(.DATA_W(16), .SHIFT(8), .ADDR_W(4), .WARMUP_SAMPLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .mic_data(mic_data), .mic_data_valid(mic_data_valid), .mic_en(mic_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .captured_count(captured_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Write/done/mic_en log sampled on the falling edge.
  logic [3:0]  wa_log [0:127];
  logic [15:0] wd_log [0:127];
  int n_wr = 0, n_done = 0, n_mic = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (wr_en && n_wr < 128) begin
      wa_log[n_wr] = wr_addr;
      wd_log[n_wr] = wr_data;
      n_wr++;
      last_wr_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (mic_en) n_mic++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_samples = 5'(n);
    cycle();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic rdy, input logic ab);
    mic_data_valid = 1'b1;
    mic_data = d;
    wr_ready = rdy;
    abort = ab;
    cycle();
    mic_data_valid = 1'b0;
    wr_ready = 1'b1;
    abort = 1'b0;
  endtask

  task automatic warmup();
    repeat (8) beat(32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (mic_en !== 1'b0) begin errors++; $display("FAIL reset_mic_en: got %b want 0", mic_en); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (wr_addr !== 4'h0 || wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_bus: got %h/%h want 0/0", wr_addr, wr_data); end
    checks++; if (captured_count !== 5'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", captured_count, drop_count); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    int b = n_wr;
    int d0 = n_done;
    do_start(4);
    checks++; if (busy !== 1'b1 || mic_en !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got busy=%b mic_en=%b want 1/1", busy, mic_en); end
    repeat (13) beat(32'h0000_1200, 1'b1, 1'b0);
    idle(3);
    checks++; if (n_wr - b !== 4) begin errors++; $display("FAIL basic_write_count: got %0d want 4", n_wr - b); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wa_log[b+i] !== 4'(i) || wd_log[b+i] !== 16'h0012) begin errors++; $display("FAIL basic_write%0d: got %h/%h want %h/0012", i, wa_log[b+i], wd_log[b+i], i); end
    end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done - d0); end
    checks++; if (done_cyc !== last_wr_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, last_wr_cyc + 1); end
    checks++; if (captured_count !== 5'd4) begin errors++; $display("FAIL basic_captured: got %0d want 4", captured_count); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL basic_drop: got %0d want 0", drop_count); end
    checks++; if (mic_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after_done: got mic_en=%b busy=%b want 0/0", mic_en, busy); end
  endtask

  task automatic test_saturation();
    int b = n_wr;
    int d0 = n_done;
    logic [15:0] exp_d [0:2];
    exp_d[0] = 16'h7FFF; exp_d[1] = 16'h8000; exp_d[2] = 16'hFFFE;
    do_start(3);
    warmup();
    beat(32'h7FFF_FFFF, 1'b1, 1'b0);
    beat(32'h8000_0000, 1'b1, 1'b0);
    beat(32'hFFFF_FE00, 1'b1, 1'b0);
    idle(3);
    checks++; if (n_wr - b !== 3) begin errors++; $display("FAIL sat_write_count: got %0d want 3", n_wr - b); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wd_log[b+i] !== exp_d[i]) begin errors++; $display("FAIL sat_data%0d: got %h want %h", i, wd_log[b+i], exp_d[i]); end
    end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL sat_done: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_backpressure();
    int b = n_wr;
    int d0 = n_done;
    logic [15:0] exp_d [0:2];
    exp_d[0] = 16'h0001; exp_d[1] = 16'h0003; exp_d[2] = 16'h0004;
    do_start(3);
    warmup();
    beat(32'h0000_0100, 1'b1, 1'b0);
    beat(32'h0000_0200, 1'b0, 1'b0);
    beat(32'h0000_0300, 1'b1, 1'b0);
    beat(32'h0000_0400, 1'b1, 1'b0);
    idle(3);
    checks++; if (n_wr - b !== 3) begin errors++; $display("FAIL bp_write_count: got %0d want 3", n_wr - b); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wa_log[b+i] !== 4'(i) || wd_log[b+i] !== exp_d[i]) begin errors++; $display("FAIL bp_write%0d: got %h/%h want %h/%h", i, wa_log[b+i], wd_log[b+i], i, exp_d[i]); end
    end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL bp_drop: got %0d want 1", drop_count); end
    checks++; if (captured_count !== 5'd3) begin errors++; $display("FAIL bp_captured: got %0d want 3", captured_count); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_abort();
    int b = n_wr;
    int d0 = n_done;
    do_start(4);
    warmup();
    beat(32'h0000_0500, 1'b1, 1'b0);
    beat(32'h0000_0600, 1'b1, 1'b1);
    checks++; if (busy !== 1'b0 || mic_en !== 1'b0) begin errors++; $display("FAIL abort_drop_enable: got busy=%b mic_en=%b want 0/0", busy, mic_en); end
    idle(4);
    checks++; if (n_wr - b !== 1 || wa_log[b] !== 4'h0 || wd_log[b] !== 16'h0005) begin errors++; $display("FAIL abort_writes: got n=%0d %h/%h want 1 0/0005", n_wr - b, wa_log[b], wd_log[b]); end
    checks++; if (n_done !== d0) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", n_done, d0); end
    checks++; if (captured_count !== 5'd1) begin errors++; $display("FAIL abort_captured_held: got %0d want 1", captured_count); end
    b = n_wr;
    do_start(2);
    checks++; if (captured_count !== 5'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL restart_clear: got %0d/%0d want 0/0", captured_count, drop_count); end
    warmup();
    beat(32'h0000_0700, 1'b1, 1'b0);
    beat(32'h0000_0800, 1'b1, 1'b0);
    idle(3);
    checks++; if (n_wr - b !== 2 || wa_log[b] !== 4'h0 || wa_log[b+1] !== 4'h1) begin errors++; $display("FAIL restart_addr: got n=%0d %h,%h want 2 0,1", n_wr - b, wa_log[b], wa_log[b+1]); end
    checks++; if (wd_log[b] !== 16'h0007 || wd_log[b+1] !== 16'h0008) begin errors++; $display("FAIL restart_data: got %h,%h want 0007,0008", wd_log[b], wd_log[b+1]); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL restart_done: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_zero_len();
    int b = n_wr;
    int d0 = n_done;
    int m0 = n_mic;
    do_start(0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || mic_en !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got done=%b busy=%b mic_en=%b want 1/0/0", done, busy, mic_en); end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done); end
    idle(2);
    checks++; if (n_mic !== m0 || n_wr !== b || n_done - d0 !== 1) begin errors++; $display("FAIL zero_side_effects: got mic=%0d wr=%0d done=%0d want 0/0/1", n_mic - m0, n_wr - b, n_done - d0); end
  endtask

  task automatic test_start_while_busy();
    int b = n_wr;
    do_start(2);
    beat(32'h0, 1'b1, 1'b0);
    beat(32'h0, 1'b1, 1'b0);
    start = 1'b1;
    num_samples = 5'd5;
    cycle();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start_kept_busy: got %b want 1", busy); end
    repeat (6) beat(32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat(32'(i + 9) << 8, 1'b1, 1'b0);
    idle(3);
    checks++; if (n_wr - b !== 2 || captured_count !== 5'd2) begin errors++; $display("FAIL busy_start_target: got n=%0d count=%0d want 2/2", n_wr - b, captured_count); end
  endtask

  task automatic test_max_len();
    int b = n_wr;
    int d0 = n_done;
    int bad = 0;
    do_start(17);
    warmup();
    for (int i = 0; i < 18; i++) beat(32'(i) << 8, 1'b1, 1'b0);
    idle(3);
    checks++; if (n_wr - b !== 16) begin errors++; $display("FAIL max_write_count: got %0d want 16", n_wr - b); end
    for (int i = 0; i < 16; i++)
      if (wa_log[b+i] !== 4'(i) || wd_log[b+i] !== 16'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL max_write_seq: got %0d bad entries want 0", bad); end
    checks++; if (captured_count !== 5'd16) begin errors++; $display("FAIL max_captured: got %0d want 16", captured_count); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL max_done: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_reset_mid_capture();
    int d0 = n_done;
    do_start(4);
    warmup();
    beat(32'h0000_0300, 1'b1, 1'b0);
    beat(32'h0000_0300, 1'b1, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || mic_en !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got busy=%b mic_en=%b wr_en=%b want 0/0/0", busy, mic_en, wr_en); end
    checks++; if (captured_count !== 5'd0 || wr_addr !== 4'h0 || wr_data !== 16'h0) begin errors++; $display("FAIL rstmid_regs: got %0d/%h/%h want 0/0/0", captured_count, wr_addr, wr_data); end
    idle(3);
    checks++; if (n_done !== d0) begin errors++; $display("FAIL rstmid_no_done: got %0d want %0d", n_done, d0); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num_samples = '0;
    mic_data = '0;
    mic_data_valid = 1'b0;
    wr_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_abort();
    test_zero_len();
    test_start_while_busy();
    test_max_len();
    test_reset_mid_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
Sequences a PDM microphone capture. On command, it enables the PDM clock/decimator path and discards the first CIC outputs while the filter settles. It then scales and saturates the 32-bit decimated samples, writes a programmed count of them to a sample buffer through a simple write port, and signals completion. It sits between the control logic and the pdm_microphone datapath on one side and the capture RAM on the other.

Parameters:
DATA_W, 16, width of stored samples (signed)
SHIFT, 8, arithmetic right shift applied to mic_data before saturation
ADDR_W, 14, buffer address width; maximum capture length is 2^ADDR_W
WARMUP_SAMPLES, 8, number of mic_data_valid beats discarded after enable (0 allowed)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle capture request
abort  in  1  single-cycle abort request
num_samples  in  ADDR_W+1  capture length, sampled on accepted start
mic_data  in  32  signed decimated sample from microphone path
mic_data_valid  in  1  qualifies mic_data, single-cycle beats
mic_en  out  1  enable for PDM clock generation and decimator path
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
wr_data  out  DATA_W  scaled, saturated sample
wr_ready  in  1  buffer can accept a write this cycle
busy  out  1  high in WARMUP and CAPTURE
done  out  1  one-cycle pulse when capture completes
captured_count  out  ADDR_W+1  samples written in the last or current capture
drop_count  out  16  samples dropped because wr_ready was low, saturating at 0xFFFF

Behaviour:
- Reset: state IDLE. mic_en, wr_en, busy and done are 0. wr_addr, wr_data, captured_count and drop_count are 0.
- States: IDLE, WARMUP, CAPTURE, DONE.
- IDLE, start=1:
  - Latch target = min(num_samples, 2^ADDR_W).
  - Clear captured_count, drop_count and the warmup counter.
  - If target==0, go to DONE.
  - Else if WARMUP_SAMPLES==0, go to CAPTURE.
  - Else go to WARMUP.
- mic_en and busy are registered. Both are 1 from the cycle after an accepted start until leaving WARMUP/CAPTURE.
- start is ignored outside IDLE.
- WARMUP: count mic_data_valid beats and discard the data. On the WARMUP_SAMPLES-th beat, go to CAPTURE (that beat is also discarded).
- CAPTURE: on each mic_data_valid beat:
  - scaled = signed(mic_data) >>> SHIFT.
  - If scaled > 2^(DATA_W-1)-1, use 2^(DATA_W-1)-1. If scaled < -2^(DATA_W-1), use -2^(DATA_W-1). Otherwise use the low DATA_W bits.
  - If wr_ready=1 in the same cycle: the next cycle has wr_en=1 for exactly one cycle, wr_addr=captured_count (pre-increment, low ADDR_W bits) and wr_data=scaled; captured_count increments.
  - If wr_ready=0: no write. drop_count increments, saturating. captured_count is unchanged.
  - Latency from mic_data_valid to wr_en is one cycle.
- When the accepted write brings captured_count to target, the next state is DONE. No further beats are accepted, even if valid arrives in the cycle wr_en is asserted.
- DONE: lasts one cycle. done=1, mic_en=0, busy=0. Next state is IDLE.
- wr_addr, wr_data, captured_count and drop_count hold their values in IDLE until the next accepted start.
- abort in WARMUP or CAPTURE: next state is IDLE.
  - mic_en and busy drop the next cycle; done is not pulsed.
  - abort in the same cycle as mic_data_valid: abort wins and no write occurs.
  - abort in IDLE or DONE has no effect. DONE still completes with its pulse.
- start and abort together in IDLE: start is accepted.
- Address wrap is not possible, since target ≤ 2^ADDR_W and addresses run from 0 to target-1.
- rst mid-capture returns to the reset state the next cycle, with no done pulse.

Test Plan:
- SHIFT=8, WARMUP=8, num_samples=4, wr_ready=1, 12 valid beats with mic_data=0x00001200 → first 8 beats discarded; writes at addr 0..3 with data 0x0012; done pulse one cycle after last wr_en; captured_count=4; mic_en low after done.
- Saturation: in CAPTURE, mic_data=0x7FFFFFFF → wr_data=0x7FFF; mic_data=0x80000000 → 0x8000; mic_data=0xFFFFFE00 → 0xFFFE.
- Backpressure: num_samples=3, wr_ready=0 on the 2nd capture beat of 4 → writes at addr 0,1,2 using beats 1,3,4; drop_count=1; captured_count=3.
- Abort on the 2nd capture beat, asserted with valid → only addr 0 written; no done; busy=0 and mic_en=0 the next cycle; a new start then restarts at addr 0 with counters cleared.
- num_samples=0 → done pulse one cycle after start; mic_en never asserted; no wr_en. start asserted while busy → ignored, target unchanged.
- num_samples=2^ADDR_W+1 (ADDR_W=4, value 17) → exactly 16 writes at addr 0..15, then done.
